// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the pipeline control logic.
//   md_state_t      - multiply/divide sequencer states
//   MULT_CYCLES_DEF - default busy length of mult/multu
//   DIV_CYCLES_DEF  - default busy length of div/divu
//   REG_ZERO        - hard-wired zero register, never a hazard source
//   reg_hazard()    - single-operand RAW hazard test against E/M destinations
package core_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2
  } md_state_t;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A load in E is never forwardable to D in time. An ALU result in E only
  // matters when D consumes operands early (branch/jr). A load in M only
  // matters for early consumers, since late consumers pick it up via
  // WB-to-E forwarding.
  function automatic logic reg_hazard(
    input logic [4:0] r,
    input logic       used,
    input logic       early_use,
    input logic [4:0] wr_e,
    input logic       wr_e_load,
    input logic       wr_e_alu,
    input logic [4:0] wr_m,
    input logic       wr_m_load
  );
    logic hz_e;
    logic hz_m;
    hz_e = (r == wr_e) && (wr_e_load || (early_use && wr_e_alu));
    hz_m = early_use && (r == wr_m) && wr_m_load;
    return used && (r != REG_ZERO) && (hz_e || hz_m);
  endfunction

endpackage

// File: rtl/md_sequencer.sv
// md_sequencer: busy sequencing for the multi-cycle multiply/divide unit.
// Ports:
//   i_clk, i_rst_n - core clock, asynchronous active-low reset
//   i_start        - E instruction launches an MD operation this cycle
//   i_is_div       - the launch is a divide (else multiply)
//   i_flush        - exception/eret this cycle; cancels a launch from idle
//   o_busy         - MD unit is computing
//   o_done         - one-cycle pulse in the last busy cycle
//   o_err          - sticky: a start arrived while busy
module md_sequencer
  import core_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_is_div,
  input  logic i_flush,
  output logic o_busy,
  output logic o_done,
  output logic o_err
);

  // Counter sized for the longest operation; keep at least one bit.
  localparam int unsigned CntW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

  md_state_t       r_state;
  md_state_t       w_state_d;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic            r_err;
  logic            w_err_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_err   <= w_err_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_err_d   = r_err;
    unique case (r_state)
      MD_IDLE: begin
        if (i_start && !i_flush) begin
          if (i_is_div) begin
            w_state_d = MD_DIV;
            w_cnt_d   = DivLoad;
          end else begin
            w_state_d = MD_MULT;
            w_cnt_d   = MultLoad;
          end
        end
      end
      MD_MULT, MD_DIV: begin
        // A running operation is never aborted by a flush; a second
        // launch (including one in the done cycle) is dropped and flagged.
        if (i_start) begin
          w_err_d = 1'b1;
        end
        if (r_cnt == '0) begin
          w_state_d = MD_IDLE;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_d = MD_IDLE;
        w_cnt_d   = '0;
      end
    endcase
  end

  assign o_busy = (r_state != MD_IDLE);
  assign o_done = o_busy && (r_cnt == '0);
  assign o_err  = r_err;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control for the five-stage MIPS pipeline.
// Ports:
//   i_clk, i_rst_n              - core clock, asynchronous active-low reset
//   i_rs_d, i_rt_d              - D source registers
//   i_use_rs_d, i_use_rt_d      - D reads rs / rt
//   i_early_use_d               - D needs operands in D (branch, jr/jalr)
//   i_md_op_d                   - D touches HI/LO or the MD unit
//   i_wr_e, i_wr_e_load         - E destination, E is a load
//   i_wr_e_alu                  - E result is ready only at M
//   i_wr_m, i_wr_m_load         - M destination, M is a load
//   i_md_start_e, i_md_is_div_e - E launches an MD op, and it is a divide
//   i_exc_req, i_eret_req       - exception / eret committing in M
//   o_fd_en                     - F/D register enable
//   o_de_flush                  - bubble into D/E
//   o_general_flush             - flush F/D, D/E, E/M
//   o_md_busy, o_md_done        - MD unit busy, last-busy-cycle pulse
//   o_md_err                    - sticky start-while-busy flag
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] i_rs_d,
  input  logic [4:0] i_rt_d,
  input  logic       i_use_rs_d,
  input  logic       i_use_rt_d,
  input  logic       i_early_use_d,
  input  logic       i_md_op_d,
  input  logic [4:0] i_wr_e,
  input  logic       i_wr_e_load,
  input  logic       i_wr_e_alu,
  input  logic [4:0] i_wr_m,
  input  logic       i_wr_m_load,
  input  logic       i_md_start_e,
  input  logic       i_md_is_div_e,
  input  logic       i_exc_req,
  input  logic       i_eret_req,
  output logic       o_fd_en,
  output logic       o_de_flush,
  output logic       o_general_flush,
  output logic       o_md_busy,
  output logic       o_md_done,
  output logic       o_md_err
);

  logic w_hz_rs;
  logic w_hz_rt;
  logic w_data_stall;
  logic w_md_stall;
  logic w_stall;
  logic w_flush;
  logic w_md_busy;

  assign w_hz_rs = reg_hazard(i_rs_d, i_use_rs_d, i_early_use_d, i_wr_e, i_wr_e_load,
                              i_wr_e_alu, i_wr_m, i_wr_m_load);
  assign w_hz_rt = reg_hazard(i_rt_d, i_use_rt_d, i_early_use_d, i_wr_e, i_wr_e_load,
                              i_wr_e_alu, i_wr_m, i_wr_m_load);

  assign w_data_stall = w_hz_rs || w_hz_rt;
  // A launch in E is counted as busy already so an mfhi/mflo right behind
  // it cannot slip past.
  assign w_md_stall   = i_md_op_d && (w_md_busy || i_md_start_e);
  assign w_stall      = w_data_stall || w_md_stall;
  assign w_flush      = i_exc_req || i_eret_req;

  // Flush overrides stall; reset forces the pipeline controls to a neutral
  // value even though the hazard path is purely combinational.
  assign o_general_flush = i_rst_n && w_flush;
  assign o_fd_en         = !i_rst_n || w_flush || !w_stall;
  assign o_de_flush      = i_rst_n && !w_flush && w_stall;
  assign o_md_busy       = w_md_busy;

  md_sequencer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_sequencer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_md_start_e),
    .i_is_div(i_md_is_div_e),
    .i_flush (w_flush),
    .o_busy  (w_md_busy),
    .o_done  (o_md_done),
    .o_err   (o_md_err)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (MULT_CYCLES=5, DIV_CYCLES=10).
module tb_hazard_ctrl;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       early;
    logic       md_op;
    logic [4:0] wr_e;
    logic       e_load;
    logic       e_alu;
    logic [4:0] wr_m;
    logic       m_load;
    logic       start;
    logic       is_div;
    logic       exc;
    logic       eret;
  } stim_t;

  typedef struct packed {
    logic fd_en;
    logic de_flush;
    logic gflush;
    logic busy;
    logic done;
    logic err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, wr_e, wr_m;
  logic       use_rs_d, use_rt_d, early_use_d, md_op_d;
  logic       wr_e_load, wr_e_alu, wr_m_load;
  logic       md_start_e, md_is_div_e, exc_req, eret_req;
  logic       fd_en, de_flush, general_flush, md_busy, md_done, md_err;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_rs_d         (rs_d),
    .i_rt_d         (rt_d),
    .i_use_rs_d     (use_rs_d),
    .i_use_rt_d     (use_rt_d),
    .i_early_use_d  (early_use_d),
    .i_md_op_d      (md_op_d),
    .i_wr_e         (wr_e),
    .i_wr_e_load    (wr_e_load),
    .i_wr_e_alu     (wr_e_alu),
    .i_wr_m         (wr_m),
    .i_wr_m_load    (wr_m_load),
    .i_md_start_e   (md_start_e),
    .i_md_is_div_e  (md_is_div_e),
    .i_exc_req      (exc_req),
    .i_eret_req     (eret_req),
    .o_fd_en        (fd_en),
    .o_de_flush     (de_flush),
    .o_general_flush(general_flush),
    .o_md_busy      (md_busy),
    .o_md_done      (md_done),
    .o_md_err       (md_err)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  exp_t  exp_q[$];
  string tag_q[$];

  // Reference MD model: remaining busy cycles including the current one.
  int    m_left = 0;
  logic  m_err  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic hz(input stim_t s, input logic [4:0] r, input logic used);
    logic e_hit;
    logic m_hit;
    e_hit = (r == s.wr_e) && (s.e_load || (s.early && s.e_alu));
    m_hit = s.early && (r == s.wr_m) && s.m_load;
    return used && (r != 5'd0) && (e_hit || m_hit);
  endfunction

  function automatic exp_t model(input stim_t s);
    exp_t e;
    logic flush;
    logic busy;
    logic stall;
    flush      = s.exc || s.eret;
    busy       = (m_left > 0);
    stall      = hz(s, s.rs, s.use_rs) || hz(s, s.rt, s.use_rt) || (s.md_op && (busy || s.start));
    e.fd_en    = flush || !stall;
    e.de_flush = !flush && stall;
    e.gflush   = flush;
    e.busy     = busy;
    e.done     = (m_left == 1);
    e.err      = m_err;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    rs_d        = s.rs;
    rt_d        = s.rt;
    use_rs_d    = s.use_rs;
    use_rt_d    = s.use_rt;
    early_use_d = s.early;
    md_op_d     = s.md_op;
    wr_e        = s.wr_e;
    wr_e_load   = s.e_load;
    wr_e_alu    = s.e_alu;
    wr_m        = s.wr_m;
    wr_m_load   = s.m_load;
    md_start_e  = s.start;
    md_is_div_e = s.is_div;
    exc_req     = s.exc;
    eret_req    = s.eret;
  endtask

  // Called just after a rising edge: drive, predict, compare mid-cycle,
  // then advance the reference model across the next edge.
  task automatic cycle(input string tag, input stim_t s);
    exp_t  e;
    string t;
    drive(s);
    exp_q.push_back(model(s));
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_eq({t, ".fd_en"}, 32'(fd_en), 32'(e.fd_en));
    check_eq({t, ".de_flush"}, 32'(de_flush), 32'(e.de_flush));
    check_eq({t, ".gflush"}, 32'(general_flush), 32'(e.gflush));
    check_eq({t, ".busy"}, 32'(md_busy), 32'(e.busy));
    check_eq({t, ".done"}, 32'(md_done), 32'(e.done));
    check_eq({t, ".err"}, 32'(md_err), 32'(e.err));
    @(posedge clk);
    if (m_left > 0) begin
      if (s.start) m_err = 1'b1;
      m_left--;
    end else if (s.start && !(s.exc || s.eret)) begin
      m_left = s.is_div ? int'(DivN) : int'(MultN);
    end
    #1;
  endtask

  function automatic stim_t md(input logic op, input logic start, input logic is_div,
                               input logic exc, input logic eret);
    stim_t s;
    s        = '0;
    s.md_op  = op;
    s.start  = start;
    s.is_div = is_div;
    s.exc    = exc;
    s.eret   = eret;
    return s;
  endfunction

  task automatic md_run(input string tag, input logic is_div);
    int n;
    n = is_div ? int'(DivN) : int'(MultN);
    cycle({tag, ".start"}, md(1'b1, 1'b1, is_div, 1'b0, 1'b0));
    for (int i = 0; i < n; i++) cycle({tag, ".busy"}, md(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    cycle({tag, ".after"}, md(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".fd_en"}, 32'(fd_en), 32'd1);
    check_eq({tag, ".de_flush"}, 32'(de_flush), 32'd0);
    check_eq({tag, ".gflush"}, 32'(general_flush), 32'd0);
    check_eq({tag, ".busy"}, 32'(md_busy), 32'd0);
    check_eq({tag, ".done"}, 32'(md_done), 32'd0);
    check_eq({tag, ".err"}, 32'(md_err), 32'd0);
  endtask

  initial begin
    stim_t s;

    // Reset with a load-use and an exception presented: outputs stay neutral.
    rst_n = 1'b0;
    s = '0; s.rs = 5'd5; s.use_rs = 1'b1; s.wr_e = 5'd5; s.e_load = 1'b1;
    s.exc = 1'b1; s.start = 1'b1; s.md_op = 1'b1;
    drive(s);
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    check_reset_outputs("reset_edge");
    @(negedge clk);
    drive('0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Load-use on rs, then the load has moved on.
    s = '0; s.rs = 5'd5; s.use_rs = 1'b1; s.wr_e = 5'd5; s.e_load = 1'b1;
    cycle("ld_use", s);
    s.wr_e = 5'd0;
    cycle("ld_use_next", s);
    // Load-use on $zero never stalls.
    s = '0; s.rs = 5'd0; s.use_rs = 1'b1; s.wr_e = 5'd0; s.e_load = 1'b1;
    cycle("ld_use_r0", s);

    // Branch after ALU producer on rt.
    s = '0; s.early = 1'b1; s.use_rt = 1'b1; s.rt = 5'd8; s.wr_e = 5'd8; s.e_alu = 1'b1;
    cycle("br_alu", s);
    s.rt = 5'd0;
    cycle("br_alu_r0", s);
    s.rt = 5'd8; s.early = 1'b0;
    cycle("alu_late", s);

    // Load in M only hurts early consumers.
    s = '0; s.early = 1'b1; s.use_rs = 1'b1; s.rs = 5'd7; s.wr_m = 5'd7; s.m_load = 1'b1;
    cycle("br_mload", s);
    s.early = 1'b0;
    cycle("late_mload", s);
    s = '0; s.use_rt = 1'b1; s.rt = 5'd9; s.wr_e = 5'd9; s.e_load = 1'b1;
    cycle("ld_use_rt", s);
    s.use_rt = 1'b0;
    cycle("ld_use_rt_unused", s);

    // Multiply with mflo held in D.
    md_run("mult", 1'b0);

    // Divide with an exception on busy cycle 3; the divide still completes.
    cycle("div.start", md(1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    for (int i = 1; i <= int'(DivN); i++) begin
      cycle("div.busy", md(1'b1, 1'b0, 1'b0, (i == 3), 1'b0));
    end
    cycle("div.after", md(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

    // Starts cancelled by eret and by an exception.
    cycle("cancel_eret", md(1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    cycle("cancel_eret.after", md(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cycle("cancel_exc", md(1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    cycle("cancel_exc.after", md(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Back-to-back start in the done cycle is dropped and flags md_err.
    cycle("b2b.start", md(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 1; i < int'(MultN); i++) cycle("b2b.busy", md(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cycle("b2b.done_start", md(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    cycle("b2b.idle1", md(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cycle("b2b.idle2", md(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Reset in the middle of busy cycle 4 of a divide.
    cycle("rdiv.start", md(1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    for (int i = 1; i <= 3; i++) cycle("rdiv.busy", md(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive(md(1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    #2;
    check_eq("rdiv.pre_busy", 32'(md_busy), 32'd1);
    check_eq("rdiv.pre_err", 32'(md_err), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rdiv.rst");
    @(posedge clk); #1;
    check_reset_outputs("rdiv.rst_edge");
    @(negedge clk);
    drive('0);
    rst_n  = 1'b1;
    m_left = 0;
    m_err  = 1'b0;
    @(posedge clk); #1;

    // Normal operation after release.
    md_run("mult2", 1'b0);
    md_run("div2", 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage MIPS core. It drives the fetch/decode pipeline register's enable, the decode/execute bubble, and the global exception flush. It also owns the busy sequencing of the multi-cycle multiply/divide unit. It sits beside the decode stage, takes register-use information from D and destination information from E/M, and closes the stall/flush loop every cycle.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1, ≥ MULT_CYCLES)
- clock  in  1  single core clock, rising edge
- reset  in  1  asynchronous, active-low
- rs_d, rt_d  in  5 each  source registers of the D instruction
- use_rs_d, use_rt_d  in  1 each  D instruction reads rs / rt
- early_use_d  in  1  D instruction needs operands in D (branch, jr/jalr)
- md_op_d  in  1  D instruction touches HI/LO or the MD unit
- wr_e  in  5  E destination register
- wr_e_load  in  1  E instruction is a load
- wr_e_alu  in  1  E result is ready only at M
- wr_m  in  5  M destination register
- wr_m_load  in  1  M instruction is a load
- md_start_e  in  1  E instruction launches an MD operation this cycle
- md_is_div_e  in  1  that launch is a divide
- exc_req  in  1  exception taken in M this cycle
- eret_req  in  1  eret committing in M this cycle
- fd_en  out  1  F/D register enable
- de_flush  out  1  insert a bubble into D/E
- general_flush  out  1  flush F/D, D/E, E/M
- md_busy  out  1  MD unit is computing
- md_done  out  1  one-cycle pulse in the last busy cycle
- md_err  out  1  sticky: a start arrived while busy

## Operation
- Register 0 never causes a hazard.
- hz(r) = (r==wr_e && (wr_e_load || (early_use_d && wr_e_alu))) || (early_use_d && r==wr_m && wr_m_load).
- data_stall = (use_rs_d && rs_d!=0 && hz(rs_d)) || (use_rt_d && rt_d!=0 && hz(rt_d)).
- md_stall = md_op_d && (md_busy || md_start_e).
- stall = data_stall || md_stall. Outputs: fd_en = !stall, de_flush = stall.
- general_flush = exc_req || eret_req. It overrides everything: fd_en=1, de_flush=0.
- MD FSM has three states: IDLE, MULT, DIV. It uses a down-counter cnt of width $clog2(DIV_CYCLES).
  - IDLE with md_start_e=1 and general_flush=0: go to DIV if md_is_div_e, else MULT. Load cnt = N-1, where N is DIV_CYCLES or MULT_CYCLES.
  - IDLE with md_start_e=1 and general_flush=1: the start is cancelled and the FSM stays IDLE.
  - MULT/DIV: cnt decrements each cycle. When cnt==0, md_done=1 and the next state is IDLE.
  - An exception or eret does not abort an MD operation that is already running.
  - md_start_e while in MULT/DIV is ignored and sets md_err, which holds until reset.
- md_busy = (state != IDLE).

## Timing
- fd_en, de_flush and general_flush are combinational from the current-cycle inputs and state. There are no registered stall paths.
- A start sampled at edge t gives md_busy=1 for exactly N cycles after t. md_done is high in the Nth of those cycles. An mfhi/mflo held in D leaves D on the first cycle after md_busy drops.
- Back-to-back: a start in the same cycle as md_done (state returning to IDLE) is ignored and flags md_err. Decode is stalled in that cycle, so this case is a protocol violation.
- While reset is asserted: state=IDLE, cnt=0, md_err=0. Outputs are forced to fd_en=1, de_flush=0, general_flush=0, md_busy=0, md_done=0. Deassertion is used synchronized to clock.
- Reset mid-operation aborts MD immediately. md_done is not emitted.

## Structure
- Shared package core_pkg holds:
  - the md_state_t enum {MD_IDLE, MD_MULT, MD_DIV}
  - default MULT_CYCLES/DIV_CYCLES constants
  - REG_ZERO = 5'd0
- One sub-module, md_sequencer, contains the FSM, the counter, and the md_busy/md_done/md_err logic. hazard_ctrl holds the combinational hazard compare and instantiates md_sequencer.

## Test plan
- Load-use: wr_e=5, wr_e_load=1, use_rs_d=1, rs_d=5 -> fd_en=0, de_flush=1 for that cycle. The next cycle, with wr_e=0, gives fd_en=1.
- Branch after ALU: early_use_d=1, rt_d=8, wr_e=8, wr_e_alu=1 -> stall. The same case with rt_d=0 -> no stall.
- Multiply: md_start_e=1, md_is_div_e=0 at edge t, with mflo held in D (md_op_d=1).
  - md_busy=1 for exactly 5 cycles, md_done pulses in cycle t+5, fd_en=0 throughout.
  - fd_en=1 on the cycle after md_busy drops.
- Divide with an exception: div starts, then exc_req=1 on busy cycle 3 -> general_flush=1, fd_en=1, de_flush=0 that cycle. md_busy stays high and completes at 10 cycles.
- Cancelled start: md_start_e=1 and eret_req=1 in the same cycle -> FSM stays IDLE, md_busy=0.
- Reset mid-operation: reset low during DIV busy cycle 4 -> md_busy=0 immediately, no md_done, md_err=0. A start after release gives normal 5/10-cycle behaviour.
